// File: rtl/pc_pkg.sv
// pc_pkg: shared types for the program-counter sequencer.
// The return-address stack is built only when PC_RAS_EN is defined.
package pc_pkg;

  // Next-PC operation codes; codes 5..7 are undefined and treated as OP_SEQ.
  typedef enum logic [2:0] {
    OP_SEQ  = 3'd0,
    OP_BR   = 3'd1,
    OP_JMP  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4
  } pc_op_t;

endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack.
// Entries live in a ring addressed by a write pointer; the live entries are
// the COUNT slots just below the pointer. Pushing onto a full stack
// overwrites the oldest slot, because that slot is the one under the pointer.
module ras_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     data_i,
  output logic [W-1:0]     data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [IDX_W-1:0] ptr_q, ptr_d, ptr_inc, ptr_dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  // Ring pointer neighbours; DEPTH need not be a power of two.
  always_comb begin
    ptr_inc = (ptr_q == IDX_W'(DEPTH - 1)) ? '0 : ptr_q + IDX_W'(1);
    ptr_dec = (ptr_q == '0) ? IDX_W'(DEPTH - 1) : ptr_q - IDX_W'(1);
  end

  // Top of stack is the slot just below the write pointer.
  assign data_o = mem_q[ptr_dec];

  // Pointer/count update; count saturates at DEPTH on overwrite, pop of empty is ignored.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_inc;
      if (!full_o) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      ptr_d = ptr_dec;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is not reset; an empty count makes stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[ptr_q] <= data_i;
  end

endmodule

// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer with optional return-address stack.
// Define PC_RAS_EN to build the stack; otherwise CALL/RET act as JMP and the
// stack status outputs are constant (ras_empty=1, ras_ovf=ras_udf=0).
module pc_seq
  import pc_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter int              INC_STEP  = 2,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(16'h0000),
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic            flush,
  input  logic [PC_W-1:0] flush_target,
  input  logic [2:0]      op,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus,
  output logic            ras_empty,
  output logic            ras_ovf,
  output logic            ras_udf
);

  if (RAS_DEPTH < 2 || RAS_DEPTH > 16) begin : g_depth_chk
    $error("pc_seq: RAS_DEPTH must be within 2..16");
  end

  logic [PC_W-1:0] pc_q, pc_d;
  pc_op_t          op_s;

  assign op_s    = pc_op_t'(op);
  assign pc      = pc_q;
  // Wraps modulo 2^PC_W by construction.
  assign pc_plus = pc_q + PC_W'(INC_STEP);

`ifdef PC_RAS_EN
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic             push, pop;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic [PC_W-1:0]  ras_top;
  logic [CNT_W-1:0] ras_count;
  logic             ras_full, ras_none;

  ras_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pc_plus),
    .data_o  (ras_top),
    .count_o (ras_count),
    .full_o  (ras_full),
    .empty_o (ras_none)
  );

  assign ras_empty = (ras_count == '0);
  assign ras_ovf   = ovf_q;
  assign ras_udf   = udf_q;
`else
  assign ras_empty = 1'b1;
  assign ras_ovf   = 1'b0;
  assign ras_udf   = 1'b0;
`endif

  // Next-PC selection: flush beats enable; a stall holds PC and stack.
  always_comb begin
    pc_d = pc_q;
`ifdef PC_RAS_EN
    push  = 1'b0;
    pop   = 1'b0;
    ovf_d = 1'b0;
    udf_d = 1'b0;
`endif
    if (flush) begin
      pc_d = flush_target;
    end else if (en) begin
      case (op_s)
        OP_SEQ:         pc_d = pc_plus;
        OP_BR, OP_JMP:  pc_d = target;
`ifdef PC_RAS_EN
        OP_CALL: begin
          pc_d  = target;
          push  = 1'b1;
          ovf_d = ras_full;
        end
        OP_RET: begin
          if (ras_none) begin
            pc_d  = target;
            udf_d = 1'b1;
          end else begin
            pc_d = ras_top;
            pop  = 1'b1;
          end
        end
`else
        OP_CALL, OP_RET: pc_d = target;
`endif
        default:        pc_d = pc_plus;
      endcase
    end
  end

  // PC register; reset forces the reset vector immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc_q <= RESET_VEC;
    else          pc_q <= pc_d;
  end

`ifdef PC_RAS_EN
  // Overflow/underflow flags: one-cycle pulses following the offending edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
`endif

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: scoreboard bench for pc_seq with a queue-based reference model.
module tb_pc_seq;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        flush;
  logic [15:0] flush_target;
  logic [2:0]  op;
  logic [15:0] target;
  logic [15:0] pc;
  logic [15:0] pc_plus;
  logic        ras_empty;
  logic        ras_ovf;
  logic        ras_udf;

  pc_seq #(
    .PC_W      (16),
    .INC_STEP  (2),
    .RESET_VEC (16'h0000),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .flush        (flush),
    .flush_target (flush_target),
    .op           (op),
    .target       (target),
    .pc           (pc),
    .pc_plus      (pc_plus),
    .ras_empty    (ras_empty),
    .ras_ovf      (ras_ovf),
    .ras_udf      (ras_udf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] pcp;
    logic        emp;
    logic        ovf;
    logic        udf;
  } exp_t;

  exp_t        sb[$];
  int          sid[$];
  logic [15:0] m_pc;
  logic [15:0] m_stk[$];
  logic        m_ovf, m_udf;
  int          total = 0;
  int          bad   = 0;
  int          nstep = 0;

  task automatic chk(input string nm, input int id, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", nm, id, act, want);
    end
  endtask

  // Drive one cycle of stimulus and queue the response expected after it.
  task automatic step(input int rst, input int e, input int fl, input int ft, input int o, input int t);
    exp_t        x;
    logic [15:0] ft16, t16;
    logic [2:0]  o3;
    ft16 = 16'(ft);
    t16  = 16'(t);
    o3   = 3'(o);
    @(negedge clk);
    reset_n      = (rst == 0);
    en           = (e != 0);
    flush        = (fl != 0);
    flush_target = ft16;
    op           = o3;
    target       = t16;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    if (rst != 0) begin
      m_pc = 16'h0000;
      m_stk.delete();
    end else if (fl != 0) begin
      m_pc = ft16;
    end else if (e != 0) begin
      case (o3)
        3'd1, 3'd2: m_pc = t16;
        3'd3: begin
`ifdef PC_RAS_EN
          m_stk.push_back(m_pc + 16'd2);
          if (m_stk.size() > DEPTH) begin
            void'(m_stk.pop_front());
            m_ovf = 1'b1;
          end
`endif
          m_pc = t16;
        end
        3'd4: begin
`ifdef PC_RAS_EN
          if (m_stk.size() == 0) begin
            m_pc  = t16;
            m_udf = 1'b1;
          end else begin
            m_pc = m_stk.pop_back();
          end
`else
          m_pc = t16;
`endif
        end
        default: m_pc = m_pc + 16'd2;
      endcase
    end
    x.pc  = m_pc;
    x.pcp = m_pc + 16'd2;
    x.emp = (m_stk.size() == 0);
    x.ovf = m_ovf;
    x.udf = m_udf;
    nstep++;
    sb.push_back(x);
    sid.push_back(nstep);
  endtask

  // Monitor: compare after every clock edge and immediately after reset assertion.
  initial begin : mon
    exp_t x;
    int   id;
    forever begin
      @(posedge clk or negedge reset_n);
      #1;
      if (sb.size() > 0) begin
        x  = sb.pop_front();
        id = sid.pop_front();
        chk("pc",        id, pc,                x.pc);
        chk("pc_plus",   id, pc_plus,           x.pcp);
        chk("ras_empty", id, {15'd0, ras_empty}, {15'd0, x.emp});
        chk("ras_ovf",   id, {15'd0, ras_ovf},   {15'd0, x.ovf});
        chk("ras_udf",   id, {15'd0, ras_udf},   {15'd0, x.udf});
      end
    end
  end

  initial begin : drv
    reset_n = 1'b1; en = 1'b0; flush = 1'b0;
    flush_target = '0; op = '0; target = '0;

    // Reset, reset held with an op pending, then three sequential steps.
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 3, 'h1234);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);

    // Call from 0010 then return.
    step(0, 1, 1, 'h0010, 0, 0);
    step(0, 1, 0, 0, 3, 'h0100);
    step(0, 1, 0, 0, 4, 'h0abc);

    // Five calls into a four-deep stack, then five returns.
    step(0, 1, 1, 'h0000, 0, 0);
    for (int i = 1; i <= 5; i++) step(0, 1, 0, 0, 3, i * 'h100);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 4, 'hdea0 + i);
    step(0, 1, 0, 0, 4, 'h0770);

    // Flush with en low and a CALL on op leaves the stack alone.
    step(0, 1, 0, 0, 3, 'h0200);
    step(0, 0, 1, 'h0800, 3, 'h1111);
    step(0, 1, 0, 0, 4, 'h3333);

    // Wrap at the top of the address space, then a three-cycle stall.
    step(0, 1, 1, 'hfffe, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 3, 'h4444);
    step(0, 1, 0, 0, 7, 'h5555);

    // Randomised traffic, weighted toward calls and returns.
    for (int i = 0; i < 400; i++) begin
      int r_rst, r_en, r_fl, r_op;
      r_rst = ($urandom_range(0, 99) < 2) ? 1 : 0;
      r_en  = ($urandom_range(0, 9) < 8) ? 1 : 0;
      r_fl  = ($urandom_range(0, 9) == 0) ? 1 : 0;
      r_op  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(3, 4)) : int'($urandom_range(0, 7));
      step(r_rst, r_en, r_fl, int'($urandom_range(0, 65535)), r_op, int'($urandom_range(0, 65535)));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("drain", nstep, 16'(sb.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
